// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch front-end for the pipelined core. Owns the fetch PC, issues in-order
// requests to instruction memory, tags each request with its PC, buffers the
// returned words in a small FIFO and hands them to decode. A redirect flushes
// the buffer, restarts fetch at the new PC and discards in-flight responses.

module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clock,
   input  logic        i_resetN,
   input  logic        i_redirectValid,
   input  logic [31:0] i_redirectPc,
   output logic        o_imemReqValid,
   output logic [31:0] o_imemReqAddr,
   input  logic        i_imemReqReady,
   input  logic        i_imemRspValid,
   input  logic [31:0] i_imemRspData,
   output logic        o_instrValid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instrPc,
   input  logic        i_instrReady
);

   // Pointer width indexes DEPTH entries; counter width must also hold DEPTH itself.
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   // Architectural state
   logic [31:0]   r_fetchPc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_dropCnt;
   logic [CW-1:0] r_count;

   // PC tag queue: one entry per request still waiting for its response
   logic [31:0]   r_pcQueue [DEPTH];
   logic [PW-1:0] r_pcqWrPtr;
   logic [PW-1:0] r_pcqRdPtr;

   // Instruction FIFO toward decode
   logic [31:0]   r_fifoPc   [DEPTH];
   logic [31:0]   r_fifoData [DEPTH];
   logic [PW-1:0] r_fifoWrPtr;
   logic [PW-1:0] r_fifoRdPtr;

   // Handshake and bookkeeping decodes
   logic          w_accept;
   logic          w_rspTake;
   logic          w_rspDrop;
   logic          w_push;
   logic          w_pop;
   logic [CW:0]   w_creditSum;
   logic [CW-1:0] w_outstandingNext;
   logic [CW-1:0] w_dropCntNext;
   logic [CW-1:0] w_countNext;

   // A credit is consumed by every in-flight request (dropped ones included)
   // and every buffered word, so a surviving response always finds FIFO space.
   assign w_creditSum    = {1'b0, r_outstanding} + {1'b0, r_count};
   assign o_imemReqValid = !i_redirectValid && (w_creditSum < DEPTH_SUM);
   assign o_imemReqAddr  = r_fetchPc;
   assign w_accept       = o_imemReqValid && i_imemReqReady;

   // Responses with nothing outstanding are stale (e.g. from before a reset) and ignored.
   assign w_rspTake = i_imemRspValid && (r_outstanding != '0);
   assign w_rspDrop = w_rspTake && (r_dropCnt != '0);
   assign w_push    = w_rspTake && !w_rspDrop && !i_redirectValid;

   // Decode sees the FIFO head directly; nothing bypasses the FIFO.
   assign o_instrValid = (r_count != '0) && !i_redirectValid;
   assign w_pop        = o_instrValid && i_instrReady;
   assign o_instr      = r_fifoData[r_fifoRdPtr];
   assign o_instrPc    = r_fifoPc[r_fifoRdPtr];

   // Outstanding moves up on accept and down on any taken response; both cancel out.
   always_comb begin
      w_outstandingNext = r_outstanding;
      if (w_accept && !w_rspTake) begin
         w_outstandingNext = r_outstanding + CNT_ONE;
      end else if (!w_accept && w_rspTake) begin
         w_outstandingNext = r_outstanding - CNT_ONE;
      end
   end

   // On redirect every request still in flight (less the one answering now) becomes a drop.
   always_comb begin
      w_dropCntNext = r_dropCnt;
      if (i_redirectValid) begin
         w_dropCntNext = w_rspTake ? (r_outstanding - CNT_ONE) : r_outstanding;
      end else if (w_rspDrop) begin
         w_dropCntNext = r_dropCnt - CNT_ONE;
      end
   end

   // FIFO occupancy: redirect empties it, otherwise push and pop net out.
   always_comb begin
      w_countNext = r_count;
      if (i_redirectValid) begin
         w_countNext = '0;
      end else if (w_push && !w_pop) begin
         w_countNext = r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_countNext = r_count - CNT_ONE;
      end
   end

   // Fetch PC: redirect wins, otherwise advance one word per accepted request (wraps at 2^32).
   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_fetchPc <= RESET_PC;
      end else if (i_redirectValid) begin
         r_fetchPc <= i_redirectPc;
      end else if (w_accept) begin
         r_fetchPc <= r_fetchPc + 32'd4;
      end
   end

   // In-flight and drop counters.
   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_outstanding <= '0;
         r_dropCnt     <= '0;
      end else begin
         r_outstanding <= w_outstandingNext;
         r_dropCnt     <= w_dropCntNext;
      end
   end

   // PC tag queue: record each accepted address, retire one per taken response (dropped or not).
   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_pcqWrPtr <= '0;
         r_pcqRdPtr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pcQueue[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_pcQueue[r_pcqWrPtr] <= r_fetchPc;
            r_pcqWrPtr            <= r_pcqWrPtr + PTR_ONE;
         end
         if (w_rspTake) begin
            r_pcqRdPtr <= r_pcqRdPtr + PTR_ONE;
         end
      end
   end

   // Instruction FIFO: pair each surviving response with its tagged PC; redirect flushes.
   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_fifoWrPtr <= '0;
         r_fifoRdPtr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_fifoPc[i]   <= '0;
            r_fifoData[i] <= '0;
         end
      end else if (i_redirectValid) begin
         r_fifoWrPtr <= '0;
         r_fifoRdPtr <= '0;
      end else begin
         if (w_push) begin
            r_fifoPc[r_fifoWrPtr]   <= r_pcQueue[r_pcqRdPtr];
            r_fifoData[r_fifoWrPtr] <= i_imemRspData;
            r_fifoWrPtr             <= r_fifoWrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_fifoRdPtr <= r_fifoRdPtr + PTR_ONE;
         end
      end
   end

   // Occupancy count register.
   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_count <= '0;
      end else begin
         r_count <= w_countNext;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Drives the fetch unit against a behavioural instruction memory with
// configurable latency and readiness. The reference view is the program
// stream: requests must walk consecutive words from the latest restart point,
// and decode must see each fetched word of the current stream, in order, with
// the word the memory holds at that PC. Responses are tagged with the reset
// epoch and redirect generation they belong to so stale ones are known to vanish.

module tb_instr_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock;
   logic        resetN;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        imemReqValid;
   logic [31:0] imemReqAddr;
   logic        imemReqReady;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        instrValid;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic        instrReady;

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clock         (clock),
      .i_resetN        (resetN),
      .i_redirectValid (redirectValid),
      .i_redirectPc    (redirectPc),
      .o_imemReqValid  (imemReqValid),
      .o_imemReqAddr   (imemReqAddr),
      .i_imemReqReady  (imemReqReady),
      .i_imemRspValid  (imemRspValid),
      .i_imemRspData   (imemRspData),
      .o_instrValid    (instrValid),
      .o_instr         (instr),
      .o_instrPc       (instrPc),
      .i_instrReady    (instrReady)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
      int          gen;
   } memReq_t;

   int          compared;
   int          mismatched;
   int          cyc;
   int          curEpoch;
   int          curGen;
   int          lastDue;
   int          readyPct;
   int          instrPct;
   int          memLat;
   int          memJit;
   bit          redirNow;
   bit          rspPresent;
   logic [31:0] redirTarget;
   logic [31:0] expReqPc;
   logic [31:0] salt;
   memReq_t     curRsp;
   memReq_t     memQ[$];
   logic [31:0] bufQ[$];
   logic [31:0] accLog[$];
   int          accCyc[$];
   logic [31:0] popLog[$];
   int          popCyc[$];

   // Contents of instruction memory: a scrambled function of the address
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   // Requests of the current reset epoch still waiting for a response
   function automatic int liveOutstanding();
      int n = 0;
      foreach (memQ[k]) if (memQ[k].epoch == curEpoch) n++;
      if (rspPresent && curRsp.epoch == curEpoch) n++;
      return n;
   endfunction

   function automatic bit oldPending();
      bit p = 0;
      foreach (memQ[k]) if (memQ[k].epoch != curEpoch) p = 1;
      return p;
   endfunction

   task automatic clearLogs();
      accLog.delete();
      accCyc.delete();
      popLog.delete();
      popCyc.delete();
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the model for the edge
   task automatic step();
      logic    expReqValid;
      logic    expInstrValid;
      int      due;
      memReq_t e;
      rspPresent = 0;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
         curRsp     = memQ.pop_front();
         rspPresent = 1;
      end
      imemRspValid  = rspPresent;
      imemRspData   = rspPresent ? memWord(curRsp.addr) : $urandom();
      imemReqReady  = (int'($urandom_range(99)) < readyPct);
      instrReady    = (int'($urandom_range(99)) < instrPct);
      redirectValid = redirNow;
      redirectPc    = redirTarget;
      @(negedge clock);
      expReqValid   = !redirNow && ((liveOutstanding() + bufQ.size()) < DEPTH);
      expInstrValid = !redirNow && (bufQ.size() != 0);
      compared++;
      if (imemReqValid !== expReqValid) begin
         mismatched++;
         $display("[TB] FAIL reqValid cyc=%0d got=%b exp=%b", cyc, imemReqValid, expReqValid);
      end
      if (expReqValid) begin
         compared++;
         if (imemReqAddr !== expReqPc) begin
            mismatched++;
            $display("[TB] FAIL reqAddr cyc=%0d got=%h exp=%h", cyc, imemReqAddr, expReqPc);
         end
      end
      compared++;
      if (instrValid !== expInstrValid) begin
         mismatched++;
         $display("[TB] FAIL instrValid cyc=%0d got=%b exp=%b", cyc, instrValid, expInstrValid);
      end
      if (expInstrValid) begin
         compared++;
         if (instrPc !== bufQ[0] || instr !== memWord(bufQ[0])) begin
            mismatched++;
            $display("[TB] FAIL instrHead cyc=%0d got pc=%h word=%h exp pc=%h word=%h",
                     cyc, instrPc, instr, bufQ[0], memWord(bufQ[0]));
         end
      end
      if (imemReqValid === 1'b1 && imemReqReady) begin
         accLog.push_back(imemReqAddr);
         accCyc.push_back(cyc);
      end
      if (instrValid === 1'b1 && instrReady) begin
         popLog.push_back(instrPc);
         popCyc.push_back(cyc);
      end
      if (redirNow) begin
         bufQ.delete();
         curGen++;
         expReqPc = redirTarget;
      end else begin
         if (expInstrValid && instrReady) void'(bufQ.pop_front());
         if (expReqValid && imemReqReady) begin
            due = cyc + memLat + int'($urandom_range(0, memJit));
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            e.addr  = expReqPc;
            e.due   = due;
            e.epoch = curEpoch;
            e.gen   = curGen;
            memQ.push_back(e);
            expReqPc = expReqPc + 32'd4;
         end
         if (rspPresent && curRsp.epoch == curEpoch && curRsp.gen == curGen) begin
            bufQ.push_back(curRsp.addr);
         end
      end
      rspPresent = 0;
      @(posedge clock);
      #1;
      cyc++;
      redirNow = 0;
   endtask

   // Assert reset mid-cycle, hold it two edges, release, then let late responses arrive unaccepted
   task automatic resetDut();
      int guard;
      redirectValid = 0;
      resetN = 0;
      #1;
      compared++;
      if (instrValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL resetInstrValid got=%b exp=0", instrValid);
      end
      compared++;
      if (imemReqValid !== 1'b1 || imemReqAddr !== RESET_PC) begin
         mismatched++;
         $display("[TB] FAIL resetReq got valid=%b addr=%h exp valid=1 addr=%h",
                  imemReqValid, imemReqAddr, RESET_PC);
      end
      curEpoch++;
      curGen++;
      bufQ.delete();
      rspPresent = 0;
      redirNow   = 0;
      expReqPc   = RESET_PC;
      repeat (2) begin
         @(posedge clock);
         cyc++;
      end
      #1;
      resetN   = 1;
      readyPct = 0;
      guard    = 0;
      while (oldPending() && guard < 50) begin
         step();
         guard++;
      end
      compared++;
      if (guard >= 50) begin
         mismatched++;
         $display("[TB] FAIL resetDrain timed out after %0d cycles, exp fewer", guard);
      end
      clearLogs();
   endtask

   task automatic test_reset();
      resetN        = 0;
      redirectValid = 0;
      redirectPc    = 0;
      imemReqReady  = 0;
      imemRspValid  = 0;
      imemRspData   = 0;
      instrReady    = 0;
      repeat (3) @(posedge clock);
      #1;
      resetN = 1;
      #1;
      compared++;
      if (instrValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rstInstrValid got=%b exp=0", instrValid);
      end
      compared++;
      if (instr !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL rstInstr got=%h exp=0", instr);
      end
      compared++;
      if (instrPc !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL rstInstrPc got=%h exp=0", instrPc);
      end
      compared++;
      if (imemReqValid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rstReqValid got=%b exp=1", imemReqValid);
      end
      compared++;
      if (imemReqAddr !== RESET_PC) begin
         mismatched++;
         $display("[TB] FAIL rstReqAddr got=%h exp=%h", imemReqAddr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      readyPct = 100;
      instrPct = 100;
      memLat   = 1;
      memJit   = 0;
      clearLogs();
      repeat (20) step();
      compared++;
      if (popLog.size() != 18 || accCyc.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL streamCount got pops=%0d accepts=%0d exp pops=18", popLog.size(), accCyc.size());
      end else begin
         compared++;
         if (popCyc[0] - accCyc[0] != 2) begin
            mismatched++;
            $display("[TB] FAIL streamLatency got=%0d exp=2", popCyc[0] - accCyc[0]);
         end
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (popLog[i] !== RESET_PC + 32'(4 * i)) begin
               mismatched++;
               $display("[TB] FAIL streamPc[%0d] got=%h exp=%h", i, popLog[i], RESET_PC + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      resetDut();
      readyPct = 100;
      instrPct = 0;
      memLat   = 1;
      memJit   = 0;
      repeat (10) step();
      compared++;
      if (accLog.size() != DEPTH) begin
         mismatched++;
         $display("[TB] FAIL bpAccepts got=%0d exp=%0d", accLog.size(), DEPTH);
      end
      compared++;
      if (imemReqValid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bpReqStopped got=%b exp=0", imemReqValid);
      end
      instrPct = 100;
      clearLogs();
      repeat (8) step();
      if (popLog.size() < 4 || accLog.size() < 1) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL bpDrain got pops=%0d accepts=%0d exp >=4 and >=1", popLog.size(), accLog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (popLog[i] !== RESET_PC + 32'(4 * i)) begin
               mismatched++;
               $display("[TB] FAIL bpPc[%0d] got=%h exp=%h", i, popLog[i], RESET_PC + 32'(4 * i));
            end
         end
         compared++;
         if (accLog[0] !== RESET_PC + 32'h10 || accCyc[0] != popCyc[0] + 1) begin
            mismatched++;
            $display("[TB] FAIL bpResume got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                     accLog[0], accCyc[0], RESET_PC + 32'h10, popCyc[0] + 1);
         end
      end
   endtask

   task automatic test_req_stall();
      int guard = 0;
      resetDut();
      readyPct = 100;
      instrPct = 100;
      memLat   = 1;
      memJit   = 0;
      while (accLog.size() < 2 && guard < 20) begin
         step();
         guard++;
      end
      readyPct = 0;
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (imemReqAddr !== RESET_PC + 32'h8) begin
            mismatched++;
            $display("[TB] FAIL stallAddr[%0d] got=%h exp=%h", i, imemReqAddr, RESET_PC + 32'h8);
         end
         step();
      end
      readyPct = 100;
      repeat (4) step();
      compared++;
      if (accLog.size() < 5) begin
         mismatched++;
         $display("[TB] FAIL stallAccepts got=%0d exp>=5", accLog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            compared++;
            if (accLog[i] !== RESET_PC + 32'(4 * i)) begin
               mismatched++;
               $display("[TB] FAIL stallSeq[%0d] got=%h exp=%h", i, accLog[i], RESET_PC + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_redirect();
      int guard = 0;
      resetDut();
      readyPct = 100;
      instrPct = 100;
      memLat   = 3;
      memJit   = 0;
      while (accLog.size() < 2 && guard < 20) begin
         step();
         guard++;
      end
      readyPct    = 0;
      redirNow    = 1;
      redirTarget = 32'h0000_0100;
      clearLogs();
      step();
      readyPct = 100;
      memLat   = 1;
      repeat (12) step();
      compared++;
      if (popLog.size() < 2 || popLog[0] !== 32'h100 || popLog[1] !== 32'h104) begin
         mismatched++;
         $display("[TB] FAIL redirFirstPc got n=%0d first=%h exp 100,104", popLog.size(),
                  (popLog.size() > 0) ? popLog[0] : 32'hx);
      end
      redirNow    = 1;
      redirTarget = 32'hFFFF_FFF8;
      clearLogs();
      step();
      repeat (10) step();
      compared++;
      if (popLog.size() < 4 || popLog[2] !== 32'h0 || popLog[3] !== 32'h4) begin
         mismatched++;
         $display("[TB] FAIL redirWrap got n=%0d exp pcs FFFFFFF8,FFFFFFFC,0,4", popLog.size());
      end
   endtask

   task automatic test_redirect_with_rsp();
      int guard = 0;
      resetDut();
      readyPct = 100;
      instrPct = 100;
      memLat   = 2;
      memJit   = 0;
      while (accLog.size() < 2 && guard < 20) begin
         step();
         guard++;
      end
      readyPct = 0;
      guard    = 0;
      while (!(memQ.size() > 0 && memQ[0].due <= cyc) && guard < 10) begin
         step();
         guard++;
      end
      compared++;
      if (liveOutstanding() != 2) begin
         mismatched++;
         $display("[TB] FAIL redirRspSetup got outstanding=%0d exp=2", liveOutstanding());
      end
      redirNow    = 1;
      redirTarget = 32'h0000_0200;
      clearLogs();
      step();
      readyPct = 100;
      memLat   = 1;
      repeat (10) step();
      compared++;
      if (popLog.size() == 0 || popLog[0] !== 32'h200) begin
         mismatched++;
         $display("[TB] FAIL redirRspFirstPc got n=%0d first=%h exp=200", popLog.size(),
                  (popLog.size() > 0) ? popLog[0] : 32'hx);
      end
   endtask

   task automatic test_reset_midstream();
      int guard = 0;
      resetDut();
      readyPct = 100;
      instrPct = 0;
      memLat   = 3;
      memJit   = 0;
      while (!(bufQ.size() >= 2 && liveOutstanding() >= 1) && guard < 30) begin
         step();
         guard++;
      end
      compared++;
      if (instrValid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL midValidBefore got=%b exp=1", instrValid);
      end
      resetDut();
      readyPct = 100;
      instrPct = 100;
      memLat   = 1;
      repeat (8) step();
      compared++;
      if (accLog.size() == 0 || accLog[0] !== RESET_PC || popLog.size() == 0 || popLog[0] !== RESET_PC) begin
         mismatched++;
         $display("[TB] FAIL midRestart got accepts=%0d pops=%0d exp first pc %h", accLog.size(),
                  popLog.size(), RESET_PC);
      end
   endtask

   task automatic test_random();
      clearLogs();
      for (int blk = 0; blk < 30; blk++) begin
         readyPct = int'($urandom_range(30, 100));
         instrPct = int'($urandom_range(20, 100));
         memLat   = int'($urandom_range(1, 4));
         memJit   = int'($urandom_range(0, 3));
         for (int k = 0; k < 50; k++) begin
            if (int'($urandom_range(99)) < 4) begin
               redirNow    = 1;
               redirTarget = $urandom() & 32'hFFFF_FFFC;
            end
            step();
         end
      end
      compared++;
      if (popLog.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL randomProgress got pops=0 exp>0");
      end
   endtask

   // Test sequence
   initial begin
      compared    = 0;
      mismatched  = 0;
      cyc         = 0;
      curEpoch    = 0;
      curGen      = 0;
      lastDue     = -1;
      redirNow    = 0;
      rspPresent  = 0;
      redirTarget = 0;
      expReqPc    = RESET_PC;
      readyPct    = 0;
      instrPct    = 0;
      memLat      = 1;
      memJit      = 0;
      salt        = $urandom();
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_redirect_with_rsp();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
